// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Arbitrates EX redirects, multi-cycle EX ops and load-use hazards.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_rs1_addr/used,
//   id_rs2_addr/used            ID source operands
//   ex_is_load, ex_reg_wen,
//   ex_rd_addr                  EX destination info
//   ex_redirect, ex_target_pc   EX branch taken / jump and its target
//   ex_mc_start, mc_done        multi-cycle op start / result pulse
//   pc_en, if_id_en, id_ex_en   stage enables
//   if_id_flush, id_ex_flush,
//   ex_mem_bubble               stage NOP injection
//   redirect_valid, redirect_pc PC mux redirect
//   mc_req                      registered start pulse to the MC unit
//   mc_err                      sticky MC timeout flag
//   stall_cycles, flush_count   perf counters
//
// Optional: define PIPE_CTRL_PERF_EN to build the perf counters;
// otherwise both counter ports are tied to zero.
module pipe_ctrl #(
   parameter int CPU_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MC_TIMEOUT     = 64,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic                      id_rs1_used,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic                      id_rs2_used,
   input  logic                      ex_is_load,
   input  logic                      ex_reg_wen,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   input  logic                      ex_redirect,
   input  logic [CPU_WIDTH-1:0]      ex_target_pc,
   input  logic                      ex_mc_start,
   input  logic                      mc_done,
   output logic                      pc_en,
   output logic                      if_id_en,
   output logic                      id_ex_en,
   output logic                      if_id_flush,
   output logic                      id_ex_flush,
   output logic                      ex_mem_bubble,
   output logic                      redirect_valid,
   output logic [CPU_WIDTH-1:0]      redirect_pc,
   output logic                      mc_req,
   output logic                      mc_err,
   output logic [CNT_WIDTH-1:0]      stall_cycles,
   output logic [CNT_WIDTH-1:0]      flush_count
);

   localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);

   typedef enum logic {
      RUN,
      MC_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic            mc_req_d;
   logic            mc_err_d;
   logic [TW-1:0]   tmo_q, tmo_d;

   logic load_use;
   logic rs1_hit;
   logic rs2_hit;
   logic done_ok;
   logic tmo_hit;

   assign rs1_hit = id_rs1_used & (id_rs1_addr == ex_rd_addr);
   assign rs2_hit = id_rs2_used & (id_rs2_addr == ex_rd_addr);
   assign load_use = ex_is_load & ex_reg_wen
                   & (ex_rd_addr != '0)
                   & (rs1_hit | rs2_hit);

   // A done pulse coinciding with the request is stale; ignore it.
   assign done_ok = mc_done & ~mc_req;
   assign tmo_hit = (tmo_q == TMO_LAST);

   always_comb begin
      state_d        = state_q;
      mc_req_d       = 1'b0;
      mc_err_d       = mc_err;
      tmo_d          = tmo_q;
      pc_en          = 1'b1;
      if_id_en       = 1'b1;
      id_ex_en       = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_bubble  = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      unique case (state_q)
         RUN: begin
            if (ex_redirect) begin
               redirect_valid = 1'b1;
               redirect_pc    = ex_target_pc;
               if_id_flush    = 1'b1;
               id_ex_flush    = 1'b1;
            end else if (ex_mc_start) begin
               pc_en         = 1'b0;
               if_id_en      = 1'b0;
               id_ex_en      = 1'b0;
               ex_mem_bubble = 1'b1;
               state_d       = MC_WAIT;
               mc_req_d      = 1'b1;
               tmo_d         = '0;
            end else if (load_use) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end
         end
         MC_WAIT: begin
            if (done_ok | tmo_hit) begin
               // Release cycle: enables stay high so EX result lands.
               state_d = RUN;
               if (tmo_hit & ~done_ok) mc_err_d = 1'b1;
            end else begin
               pc_en         = 1'b0;
               if_id_en      = 1'b0;
               id_ex_en      = 1'b0;
               ex_mem_bubble = 1'b1;
               tmo_d         = tmo_q + 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         mc_req  <= 1'b0;
         mc_err  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         mc_req  <= mc_req_d;
         mc_err  <= mc_err_d;
         tmo_q   <= tmo_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_WIDTH-1:0] stall_q;
   logic [CNT_WIDTH-1:0] flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
         if (redirect_valid && (flush_q != '1))
            flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
